// File: rtl/calc_pkg.sv
// calc_pkg: shared calculator widths and result converter state encoding
package calc_pkg;
  localparam int OPERAND_W  = 8;
  localparam int RESULT_W   = 16;
  localparam int BCD_DIGITS = 5;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    FINISH = 2'b10
  } conv_state_t;
endpackage

// File: rtl/result_bcd_if.sv
// result_bcd_if: ALU result in, BCD display data out, start/busy/done handshake
interface result_bcd_if import calc_pkg::*; #(parameter int WIDTH = RESULT_W, parameter int DIGITS = BCD_DIGITS);
  logic                  start;
  logic [WIDTH-1:0]      RESULT;
  logic                  NEG;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  sign;
  logic [DIGITS-1:0]     blank;
  modport master (output start, RESULT, NEG, input busy, done, bcd, sign, blank);
  modport slave (input start, RESULT, NEG, output busy, done, bcd, sign, blank);
endinterface

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to nibbles of 5 or more
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/result_bcd_converter.sv
// result_bcd_converter: iterative double-dabble of signed-magnitude ALU result to display BCD
module result_bcd_converter import calc_pkg::*; #(
  parameter int WIDTH  = RESULT_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input logic         clk,
  input logic         reset,
  result_bcd_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  conv_state_t         state;
  logic [WIDTH-1:0]    bin;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] adj;
  logic [CW-1:0]       cnt;
  logic                neg_q;
  logic                nz_q;
  logic [DIGITS-1:0]   blank_n;
  for (genvar d = 0; d < DIGITS; d++) begin : g_add3
    bcd_add3 u_add3 (.din(scratch[4*d +: 4]), .dout(adj[4*d +: 4]));
  end
  // a digit blanks only if it and every more significant digit are zero; ones digit always shows
  always_comb begin
    blank_n = '0;
    blank_n[DIGITS-1] = scratch[4*(DIGITS-1) +: 4] == 4'd0;
    for (int i = DIGITS - 2; i >= 1; i--)
      blank_n[i] = blank_n[i+1] && (scratch[4*i +: 4] == 4'd0);
    blank_n[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bin       <= '0;
      scratch   <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      nz_q      <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.bcd   <= '0;
      bus.sign  <= 1'b0;
      bus.blank <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          bin      <= bus.RESULT;
          neg_q    <= bus.NEG;
          nz_q     <= bus.RESULT != '0;
          scratch  <= '0;
          cnt      <= '0;
          bus.busy <= 1'b1;
          state    <= SHIFT;
        end
        SHIFT: begin
          {scratch, bin} <= {adj, bin} << 1;
          cnt            <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FINISH;
        end
        FINISH: begin
          bus.bcd   <= scratch;
          bus.sign  <= neg_q && nz_q;
          bus.blank <= blank_n;
          bus.done  <= 1'b1;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/result_bcd_converter.md
Name: result_bcd_converter

Overview:
- Reads the ALU's result interface: 16-bit RESULT magnitude plus NEG sign flag.
- Converts the value to packed BCD digits with a sign bit and a leading-zero blank mask, ready for the calculator's 7-segment display driver.
- Iterative double-dabble converter: one shift per clock, with a start/busy/done handshake toward the calculator control FSM.

Parameters:
- WIDTH, 16: binary input width; equals the ALU RESULT width.
- DIGITS, 5: number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- RESULT  input  WIDTH  unsigned magnitude from the ALU.
- NEG  input  1  sign flag from the ALU (1 = negative).
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new outputs are valid.
- bcd  output  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0].
- sign  output  1  registered sign of the displayed value.
- blank  output  DIGITS  bit i=1 means digit i is a leading zero to be blanked.

Behaviour:
- Reset (clk edge with reset=1):
  - state goes to IDLE.
  - busy=0, done=0, bcd=0, sign=0, blank=0.
  - Scratch registers and shift counter are cleared.
  - Reset has priority over every other event.
- States:
  - IDLE -> SHIFT on start=1.
  - SHIFT -> SHIFT while counter < WIDTH-1.
  - SHIFT -> FINISH when counter == WIDTH-1.
  - FINISH -> IDLE unconditionally.
- IDLE, start=1:
  - Latch RESULT into the binary shift register and NEG into neg_q.
  - Clear the BCD scratch and set counter=0.
  - busy goes 1 from the next cycle.
- SHIFT, each cycle:
  - Every scratch nibble >= 5 gets +3.
  - Then {scratch, bin} shifts left 1 bit.
  - counter increments.
  - Exactly WIDTH shifts are performed.
- FINISH:
  - Load bcd from scratch.
  - Compute sign = neg_q AND (latched value != 0), so -0 is shown as 0.
  - Compute blank and pulse done=1 for one cycle.
  - busy drops to 0 in the same cycle done is high.
- Latency: done is high in the cycle after edge number WIDTH+1, counting the start-sampling edge as edge 0. For WIDTH=16 that is 17 cycles.
- RESULT/NEG are sampled only at start acceptance. Changes during a conversion have no effect.
- start while busy=1 is ignored; no queuing.
- start in the cycle done is high is accepted, because the FSM is already in IDLE. This gives back-to-back conversions every WIDTH+2 cycles.
- bcd, sign and blank hold their values between done pulses.
- Blank rule: bit i=1 iff digits DIGITS-1..i are all zero, for i >= 1. Bit 0 is always 0, so a value of 0 shows as a single "0".
- Reset during SHIFT or FINISH aborts the conversion: no done pulse, outputs are cleared to zero.

Decomposition:
- Shared package calc_pkg holds:
  - OPERAND_W=8, RESULT_W=16, BCD_DIGITS=5.
  - The converter state encoding: IDLE=2'b00, SHIFT=2'b01, FINISH=2'b10.
- One sub-module, bcd_add3: 4-bit in/out, adds 3 when the input is >= 5. It is combinational and instantiated DIGITS times inside a generate loop.
- All sequential logic stays in result_bcd_converter.

Test Plan:
- Power-on reset:
  - Stimulus: reset=1 for 2 cycles, then 0, no start.
  - Required: busy=0, done=0, bcd=20'h00000, sign=0, blank=5'b00000, all stable.
- Zero value:
  - Stimulus: RESULT=16'h0000, NEG=1, start 1 cycle.
  - Required: done pulses exactly 17 cycles later; bcd=20'h00000, sign=0, blank=5'b11110.
- Maximum value:
  - Stimulus: RESULT=16'hFFFF, NEG=0.
  - Required: bcd=20'h65535, blank=5'b00000, sign=0; busy high for 17 cycles.
- Addition result:
  - Stimulus: RESULT=16'h01B8 (0xC2+0xF6=440).
  - Required: bcd=20'h00440, blank=5'b11000.
  - Follow-on: RESULT=16'd93, NEG=1 gives bcd=20'h00093, sign=1, blank=5'b11100.
- Handshake:
  - Stimulus: start for RESULT=16'd126 (0x12*0x07). Change RESULT to 16'd999 and pulse start again 5 cycles later. Then start a new RESULT=16'd7 in the same cycle done is high.
  - Required: the first done shows bcd=20'h00126 (the second start is ignored). The next done, exactly 18 cycles after the first, shows 20'h00007.
- Reset mid-conversion:
  - Stimulus: start with RESULT=16'd4660; assert reset on cycle 8.
  - Required: no done pulse; outputs go to 0 on the next edge; a subsequent start converts normally to bcd=20'h04660.
